// File: rtl/bcd_sub_seq.sv
// Multi-digit BCD subtraction sequencer: walks packed BCD operands LSD-first through an
// external modulo-10 digit subtractor, adding borrow, sign detection and magnitude recovery.
module bcd_sub_seq #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] result,
    output logic              neg,
    output logic              err,
    output logic [3:0]        dig1,
    output logic [3:0]        dig2,
    input  logic [3:0]        res
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    typedef enum logic [1:0] {S_IDLE, S_SUB, S_COMP, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NDIG-1:0][3:0]  r_a;
    logic [NDIG-1:0][3:0]  r_b;
    logic [NDIG-1:0][3:0]  r_res;
    logic [NDIG-1:0][3:0]  w_a_d;
    logic [NDIG-1:0][3:0]  w_b_d;
    logic [IW-1:0]         r_idx;
    logic                  r_borrow;
    logic                  r_neg;
    logic                  r_err;
    logic                  w_last;
    logic                  w_borrow_nxt;
    logic                  w_in_err;
    logic [3:0]            w_corr;

    assign w_a_d = a;
    assign w_b_d = b;

    always_comb begin
        w_in_err = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (w_a_d[i] > 4'd9 || w_b_d[i] > 4'd9) begin
                w_in_err = 1'b1;
            end
        end
    end

    // Subtractor output is mod 10 only; apply the incoming borrow and derive the outgoing one.
    assign w_last       = (r_idx == LAST);
    assign w_corr       = r_borrow ? ((res == 4'd0) ? 4'd9 : res - 4'd1) : res;
    assign w_borrow_nxt = ({1'b0, dig1} < ({1'b0, dig2} + {4'b0000, r_borrow}));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SUB;
            S_SUB:   if (w_last) w_state_nxt = w_borrow_nxt ? S_COMP : S_DONE;
            S_COMP:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
        dig1 = '0;
        dig2 = '0;
        case (r_state)
            S_SUB: begin
                dig1 = r_a[r_idx];
                dig2 = r_b[r_idx];
            end
            S_COMP: begin
                dig2 = r_res[r_idx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= w_a_d;
                        r_b      <= w_b_d;
                        r_res    <= '0;
                        r_idx    <= '0;
                        r_borrow <= 1'b0;
                        r_neg    <= 1'b0;
                        r_err    <= w_in_err;
                    end
                end
                S_SUB, S_COMP: begin
                    r_res[r_idx] <= w_corr;
                    r_borrow     <= w_borrow_nxt;
                    r_idx        <= r_idx + 1'b1;
                    // COMP reuses the SUB datapath as 0 - result, giving the ten's complement.
                    if (w_last) begin
                        r_idx    <= '0;
                        r_borrow <= 1'b0;
                        if (r_state == S_SUB && w_borrow_nxt) begin
                            r_neg <= 1'b1;
                        end else if (r_err) begin
                            r_res <= '0;
                            r_neg <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_res;
    assign neg    = r_neg;
    assign err    = r_err;

endmodule

// File: tb/tb_bcd_sub_seq.sv
// Self-checking bench for bcd_sub_seq with a behavioural digit subtractor and integer reference model.
module tb_bcd_sub_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         neg;
    logic         err;
    logic [3:0]   dig1;
    logic [3:0]   dig2;
    logic [3:0]   res;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // External single-digit modulo-10 subtractor.
    always_comb res = 4'((int'(dig1) - int'(dig2) + 20) % 10);

    bcd_sub_seq #(.NDIG(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .neg(neg), .err(err),
        .dig1(dig1), .dig2(dig2), .res(res)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic n, output int lat);
        int xv = 0;
        int yv = 0;
        int p  = 1;
        int d;
        for (int i = 0; i < N; i++) begin
            xv += int'(x[4*i +: 4]) * p;
            yv += int'(y[4*i +: 4]) * p;
            p  *= 10;
        end
        d = xv - yv;
        n = (d < 0);
        if (d < 0) d = -d;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
        lat = n ? 2 * N : N;
    endfunction

    // Drives one operation; reports the edge index (after E0) at which done was seen.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit inject,
                          output int dk, output logic [W-1:0] r, output logic n, output logic e,
                          output logic [3:0] d1, output logic [3:0] d2,
                          output bit busy_ok, output bit idle_ok);
        busy_ok = 1'b1;
        idle_ok = 1'b0;
        dk      = -1;
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        d1    = dig1;
        d2    = dig2;
        if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
        for (int k = 1; k <= 3 * N + 4 && dk < 0; k++) begin
            if (inject && k == 1) begin
                start = 1'b1;
                a     = ~x;
                b     = x;
            end
            if (inject && k == 2) start = 1'b0;
            @(posedge clk);
            #1;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) dk = k;
        end
        r = result;
        n = neg;
        e = err;
        @(posedge clk);
        #1;
        idle_ok = (busy === 1'b0) && (done === 1'b0) && (result === r) && (neg === n) &&
                  (err === e) && (dig1 === 4'd0) && (dig2 === 4'd0);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, neg, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/done/neg/err=%b expected 0000", {busy, done, neg, err});
        end
        n_checks++;
        if (result !== '0) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 0000", result);
        end
        n_checks++;
        if ({dig1, dig2} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_digits: got dig1=%h dig2=%h expected 0 0", dig1, dig2);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] tx [5] = '{16'h4321, 16'h0003, 16'h1000, 16'h0000, 16'h5555};
        logic [W-1:0] ty [5] = '{16'h1234, 16'h0005, 16'h0001, 16'h9999, 16'h5555};
        logic [W-1:0] tr [5] = '{16'h3087, 16'h0002, 16'h0999, 16'h9999, 16'h0000};
        logic         tn [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int dk;
        logic [W-1:0] r;
        logic n, e;
        logic [3:0] d1, d2;
        bit bok, iok;
        for (int i = 0; i < 5; i++) begin
            run_op(tx[i], ty[i], 1'b0, dk, r, n, e, d1, d2, bok, iok);
            n_checks++;
            if ({r, n, e} !== {tr[i], tn[i], 1'b0}) begin
                n_fail++;
                $display("FAIL directed_value[%0d]: got result=%h neg=%b err=%b expected result=%h neg=%b err=0",
                         i, r, n, e, tr[i], tn[i]);
            end
            n_checks++;
            if (dk !== (tn[i] ? 2 * N : N) || !bok || !iok) begin
                n_fail++;
                $display("FAIL directed_timing[%0d]: got done_edge=%0d busy_ok=%0d idle_ok=%0d expected done_edge=%0d 1 1",
                         i, dk, bok, iok, tn[i] ? 2 * N : N);
            end
            n_checks++;
            if ({d1, d2} !== {tx[i][3:0], ty[i][3:0]}) begin
                n_fail++;
                $display("FAIL directed_digits[%0d]: got dig1=%h dig2=%h expected %h %h",
                         i, d1, d2, tx[i][3:0], ty[i][3:0]);
            end
        end
    endtask

    // Follows test_directed directly: start lands in the single IDLE cycle after done.
    task automatic test_back_to_back();
        int dk;
        logic [W-1:0] r;
        logic n, e;
        logic [3:0] d1, d2;
        bit bok, iok;
        run_op(16'h0001, 16'h0000, 1'b0, dk, r, n, e, d1, d2, bok, iok);
        n_checks++;
        if ({r, n, e} !== {16'h0001, 1'b0, 1'b0} || dk !== N || !bok || !iok) begin
            n_fail++;
            $display("FAIL back_to_back: got result=%h neg=%b err=%b done_edge=%0d busy_ok=%0d idle_ok=%0d expected 0001 0 0 %0d 1 1",
                     r, n, e, dk, bok, iok, N);
        end
    endtask

    task automatic test_ignored_start();
        int dk;
        logic [W-1:0] r;
        logic n, e;
        logic [3:0] d1, d2;
        bit bok, iok;
        run_op(16'h0003, 16'h0005, 1'b1, dk, r, n, e, d1, d2, bok, iok);
        n_checks++;
        if ({r, n, e} !== {16'h0002, 1'b1, 1'b0} || dk !== 2 * N || !bok || !iok) begin
            n_fail++;
            $display("FAIL ignored_start: got result=%h neg=%b err=%b done_edge=%0d busy_ok=%0d idle_ok=%0d expected 0002 1 0 %0d 1 1",
                     r, n, e, dk, bok, iok, 2 * N);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        bit saw_busy = 1'b0;
        @(negedge clk);
        a     = 16'h0003;
        b     = 16'h0005;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, neg, err, result, dig1, dig2} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b neg=%b err=%b result=%h dig1=%h dig2=%h expected all 0",
                     busy, done, neg, err, result, dig1, dig2);
        end
        rst = 1'b0;
        repeat (2 * N + 4) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        n_checks++;
        if (saw_done || saw_busy) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got done_seen=%0d busy_seen=%0d expected 0 0", saw_done, saw_busy);
        end
    endtask

    task automatic test_error();
        logic [W-1:0] ex [4] = '{16'h000A, 16'h0A00, 16'h0005, 16'h0042};
        logic [W-1:0] ey [4] = '{16'h0001, 16'h1000, 16'h00F0, 16'h0017};
        int           el [4] = '{N, 2 * N, 2 * N, N};
        logic         ee [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] er [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0025};
        int dk;
        logic [W-1:0] r;
        logic n, e;
        logic [3:0] d1, d2;
        bit bok, iok;
        for (int i = 0; i < 4; i++) begin
            run_op(ex[i], ey[i], 1'b0, dk, r, n, e, d1, d2, bok, iok);
            n_checks++;
            if ({r, n, e} !== {er[i], 1'b0, ee[i]}) begin
                n_fail++;
                $display("FAIL error_value[%0d]: got result=%h neg=%b err=%b expected result=%h neg=0 err=%b",
                         i, r, n, e, er[i], ee[i]);
            end
            n_checks++;
            if (dk !== el[i] || !bok || !iok) begin
                n_fail++;
                $display("FAIL error_timing[%0d]: got done_edge=%0d busy_ok=%0d idle_ok=%0d expected %0d 1 1",
                         i, dk, bok, iok, el[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, mr;
        logic mn;
        int lat;
        int dk;
        logic [W-1:0] r;
        logic n, e;
        logic [3:0] d1, d2;
        bit bok, iok;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) begin
                x[4*i +: 4] = 4'($urandom_range(9));
                y[4*i +: 4] = 4'($urandom_range(9));
            end
            model(x, y, mr, mn, lat);
            run_op(x, y, 1'b0, dk, r, n, e, d1, d2, bok, iok);
            n_checks++;
            if ({r, n, e} !== {mr, mn, 1'b0} || dk !== lat || !bok || !iok) begin
                n_fail++;
                $display("FAIL random[%0d] a=%h b=%h: got result=%h neg=%b err=%b done_edge=%0d busy_ok=%0d idle_ok=%0d expected %h %b 0 %0d 1 1",
                         t, x, y, r, n, e, dk, bok, iok, mr, mn, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid();
        test_error();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
